// File: rtl/envelope_pkg.sv
// Shared width constants for the envelope-detection chain.
//   IN_WIDTH    : width of the unsigned envelope magnitude entering the chain
//   NORM_WIDTH  : width of the left-justified mantissa handed to the log stage
//   SHIFT_WIDTH : width of the exponent (leading-one index) handed to the log stage
//   FRAC_WIDTH  : fractional width of the log2 result produced downstream
package envelope_pkg;

    localparam int IN_WIDTH    = 32;
    localparam int NORM_WIDTH  = 16;
    localparam int SHIFT_WIDTH = 5;
    localparam int FRAC_WIDTH  = 8;

endpackage : envelope_pkg

// File: rtl/leading_one_detect.sv
// Combinational leading-one detector (priority encoder on the highest set bit).
// Ports:
//   data    : input word
//   pos     : bit index of the most-significant one (0 when data is zero)
//   is_zero : high when data has no bits set
module leading_one_detect
    import envelope_pkg::*;
#(
    parameter int WIDTH = envelope_pkg::IN_WIDTH
) (
    input  logic [WIDTH-1:0]         data,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     is_zero
);

    always_comb begin
        // NOTE: default every always_comb output before any conditional write, otherwise a latch is inferred.
        pos = '0;
        // Ascending scan: the last set bit visited is the most significant one.
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                pos = ($clog2(WIDTH))'(i);
            end
        end
    end

    assign is_zero = ~|data;

endmodule : leading_one_detect

// File: rtl/envelope_normalizer.sv
// Two-stage normalizer feeding the log2 stage.
// Stage 1 registers the sample together with its leading-one index; stage 2
// left-justifies the sample and registers mantissa, exponent and zero flag.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake, in_ready is combinational from out_ready
//   data_in             : unsigned envelope magnitude
//   out_valid/out_ready : output handshake, outputs held while stalled
//   norm_out            : top NORM_WIDTH bits of data << (IN_WIDTH-1-lead)
//   shift_out           : lead, bit index of the most-significant one
//   zero_flag           : input was zero (norm_out and shift_out are then 0)
module envelope_normalizer
    import envelope_pkg::*;
#(
    parameter int IN_WIDTH    = envelope_pkg::IN_WIDTH,
    parameter int NORM_WIDTH  = envelope_pkg::NORM_WIDTH,
    parameter int SHIFT_WIDTH = $clog2(IN_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_WIDTH-1:0]    data_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NORM_WIDTH-1:0]  norm_out,
    output logic [SHIFT_WIDTH-1:0] shift_out,
    output logic                   zero_flag
);

    // Stage 1 state
    logic                   s1_valid;
    logic [IN_WIDTH-1:0]    s1_data;
    logic [SHIFT_WIDTH-1:0] s1_lead;
    logic                   s1_zero;

    // Leading-one detection on the incoming sample
    logic [SHIFT_WIDTH-1:0] lod_pos;
    logic                   lod_zero;

    // Stage 2 datapath
    logic [SHIFT_WIDTH-1:0] shift_amt;
    logic [IN_WIDTH-1:0]    shifted;

    logic s2_load;
    logic in_xfer;

    leading_one_detect #(
        .WIDTH (IN_WIDTH)
    ) u_lod (
        .data    (data_in),
        .pos     (lod_pos),
        .is_zero (lod_zero)
    );

    // Stage 2 may load when it is empty or is being drained this cycle; stage 1
    // may accept when it is empty or is moving into stage 2 this cycle.
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !reset && (!s1_valid || s2_load);
    assign in_xfer  = in_valid && in_ready;

    // The leading one lands exactly at bit IN_WIDTH-1, so nothing is shifted out.
    assign shift_amt = SHIFT_WIDTH'(IN_WIDTH - 1) - s1_lead;
    assign shifted   = s1_data << shift_amt;

    // NOTE: the stage-1 payload is only ever observed while s1_valid is high, so it carries no reset.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            s1_data <= data_in;
            s1_lead <= lod_pos;
            s1_zero <= lod_zero;
        end
    end

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            norm_out  <= '0;
            shift_out <= '0;
            zero_flag <= 1'b0;
        end else begin
            if (in_xfer) begin
                s1_valid <= 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                out_valid <= 1'b1;
                zero_flag <= s1_zero;
                if (s1_zero) begin
                    norm_out  <= '0;
                    shift_out <= '0;
                end else begin
                    norm_out  <= shifted[IN_WIDTH-1 -: NORM_WIDTH];
                    shift_out <= s1_lead;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule : envelope_normalizer

// File: tb/tb_envelope_normalizer.sv
module tb_envelope_normalizer;

    localparam int IW = 32;
    localparam int NW = 16;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] data_in;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] norm_out;
    logic [SW-1:0] shift_out;
    logic          zero_flag;

    typedef struct {
        logic [NW-1:0] norm;
        logic [SW-1:0] shift;
        logic          zero;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   n_in        = 0;

    envelope_normalizer #(
        .IN_WIDTH    (IW),
        .NORM_WIDTH  (NW),
        .SHIFT_WIDTH (SW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .norm_out  (norm_out),
        .shift_out (shift_out),
        .zero_flag (zero_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: floor(log2(x)) by repeated halving, mantissa = x * 2^(31-lead) truncated to 16 bits.
    function automatic exp_t model(input logic [IW-1:0] x);
        exp_t   e;
        int     lead;
        longint scaled;
        if (x == 0) begin
            e.norm = '0; e.shift = '0; e.zero = 1'b1;
        end else begin
            lead = 0;
            while ((x >> (lead + 1)) != 0) lead++;
            scaled  = longint'(x) * (longint'(1) << (IW - 1 - lead));
            e.norm  = NW'(scaled >> (IW - NW));
            e.shift = SW'(lead);
            e.zero  = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [IW-1:0] rand_data();
        if ($urandom_range(0, 15) == 0) return '0;
        return $urandom >> $urandom_range(0, 31);
    endfunction

    // Scoreboard: sample handshakes on the falling edge, ahead of the transferring rising edge.
    logic          held = 1'b0;
    logic [NW-1:0] held_norm;
    logic [SW-1:0] held_shift;
    logic          held_zero;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                held = 1'b0;
            end else begin
                if (out_valid) begin
                    if (held) begin
                        check("stall_norm",  32'(norm_out),  32'(held_norm));
                        check("stall_shift", 32'(shift_out), 32'(held_shift));
                        check("stall_zero",  32'(zero_flag), 32'(held_zero));
                    end
                    if (out_ready) begin
                        check("out_expected", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("sb_norm",  32'(norm_out),  32'(e.norm));
                            check("sb_shift", 32'(shift_out), 32'(e.shift));
                            check("sb_zero",  32'(zero_flag), 32'(e.zero));
                        end
                        held = 1'b0;
                    end else begin
                        held       = 1'b1;
                        held_norm  = norm_out;
                        held_shift = shift_out;
                        held_zero  = zero_flag;
                    end
                end else begin
                    held = 1'b0;
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(model(data_in));
                    n_in++;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [IW-1:0] d, input logic [NW-1:0] en,
                            input logic [SW-1:0] es, input logic ez);
        in_valid = 1'b1;
        data_in  = d;
        tick();
        in_valid = 1'b0;
        check("lat1_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat2_valid", 32'(out_valid), 32'd1);
        check("lat2_norm",  32'(norm_out),  32'(en));
        check("lat2_shift", 32'(shift_out), 32'(es));
        check("lat2_zero",  32'(zero_flag), 32'(ez));
        tick();
    endtask

    task automatic drain();
        int k;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 20) begin
            tick();
            k++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [IW-1:0] bb_data [3];
        logic [NW-1:0] bb_norm [3];
        logic [SW-1:0] bb_shift[3];
        int            accepted;
        int            cyc;
        logic          acc;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        repeat (3) tick();

        // Reset state
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_norm",      32'(norm_out),  32'd0);
        check("rst_shift",     32'(shift_out), 32'd0);
        check("rst_zero",      32'(zero_flag), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single sample, two-cycle latency
        out_ready = 1'b1;
        send_one(32'h0000_0001, 16'h8000, 5'd0, 1'b0);

        // Back-to-back samples at full rate
        bb_data  = '{32'h0000_0003, 32'hFFFF_FFFF, 32'h0001_2345};
        bb_norm  = '{16'hC000, 16'hFFFF, 16'h91A2};
        bb_shift = '{5'd1, 5'd31, 5'd16};
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                in_valid = 1'b1;
                data_in  = bb_data[i];
                #0;
                check("bb_in_ready", 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 3) begin
                check("bb_valid", 32'(out_valid),  32'd1);
                check("bb_norm",  32'(norm_out),   32'(bb_norm[i-1]));
                check("bb_shift", 32'(shift_out),  32'(bb_shift[i-1]));
                check("bb_zero",  32'(zero_flag),  32'd0);
            end
        end
        drain();

        // Zero input, then the largest power of two
        send_one(32'h0000_0000, 16'h0000, 5'd0, 1'b1);
        send_one(32'h8000_0000, 16'h8000, 5'd31, 1'b0);
        drain();

        // Backpressure: at most two samples buffered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 32'h0000_0100;
        accepted  = 0;
        for (int i = 0; i < 6; i++) begin
            acc = in_ready;
            tick();
            if (acc) begin
                accepted++;
                data_in = data_in + 1;
            end
        end
        check("bp_accepted",  32'(accepted),  32'd2);
        check("bp_in_ready",  32'(in_ready),  32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_shift",     32'(shift_out), 32'd8);
        check("bp_norm",      32'(norm_out),  32'h8000);
        out_ready = 1'b1;
        #0;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        repeat (4) begin
            acc = in_ready;
            tick();
            if (acc) data_in = data_in + 1;
        end
        drain();

        // Randomized traffic against the reference model
        n_in = 0;
        cyc  = 0;
        while (n_in < 10000 && cyc < 60000) begin
            in_valid  = 1'($urandom_range(0, 1));
            data_in   = rand_data();
            out_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        check("rand_completed", 32'(n_in >= 10000), 32'd1);
        drain();

        // Reset with two samples in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 32'h0000_ABCD;
        tick();
        data_in   = 32'h0000_1234;
        tick();
        in_valid  = 1'b0;
        check("flight_out_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #0;
        check("flight_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b0;
        #0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_norm",      32'(norm_out),  32'd0);
        check("midrst_shift",     32'(shift_out), 32'd0);
        check("midrst_zero",      32'(zero_flag), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        out_ready = 1'b1;
        repeat (5) begin
            tick();
            check("no_stale", 32'(out_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_envelope_normalizer
